// File: rtl/pwm_pkg.sv
// Purpose : shared types and constants for the PWM period/high-time capture block.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package pwm_pkg;

   // Default counter / measurement width in bits.
   localparam int PWM_WIDTH_DEFAULT = 16;

   // Measurement FSM:
   //   IDLE - no reference rising edge seen yet
   //   HIGH - synchronized input high since the last rise
   //   LOW  - synchronized input low since the last fall
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } pwm_state_e;

endpackage

// File: rtl/sync_edge.sv
// Purpose : multi-flop synchronizer for an asynchronous input plus rise/fall detection.
// Latency : input reaches the synchronized value after SYNC_STAGES clk_i cycles; edge flags are combinational on it.
// Backpressure: none; free-running, one edge flag per cycle at most.
//
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-high reset, clears every flop
//   d_i    - asynchronous input
//   rise_o - synchronized value is 1 and was 0 the previous cycle
//   fall_o - synchronized value is 0 and was 1 the previous cycle
module sync_edge #(
   parameter int SYNC_STAGES = 2   // at least 2 for metastability settling
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_dly_q;
   logic                   s;

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q  <= '0;
         s_dly_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], d_i};
         s_dly_q <= s;
      end
   end

   assign rise_o = s & ~s_dly_q;
   assign fall_o = ~s & s_dly_q;

endmodule

// File: rtl/pwm_capture.sv
// Purpose : measures period and high time of an asynchronous PWM input in clk_i cycles.
// Latency : results appear the cycle after the synchronized rise that closes a period (SYNC_STAGES+1 after in_i).
// Backpressure: none; valid_o is a one-cycle pulse, results hold until the next complete period or clear.
//
// Ports:
//   clk_i     - clock, rising edge
//   rst_i     - asynchronous active-high reset
//   in_i      - asynchronous PWM input
//   clr_i     - synchronous clear of all measurement state (synchronizer untouched)
//   period_o  - length of the last complete period
//   high_o    - high time of the last complete period
//   valid_o   - pulses when period_o/high_o update
//   timeout_o - sticky: no terminating edge within 2^WIDTH-1 cycles of the reference rise
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int WIDTH       = PWM_WIDTH_DEFAULT,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] period_o,
   output logic [WIDTH-1:0] high_o,
   output logic             valid_o,
   output logic             timeout_o
);

   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   pwm_state_e       state_q;
   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] high_lat_q;
   logic [WIDTH-1:0] period_q;
   logic [WIDTH-1:0] high_q;
   logic             valid_q;
   logic             timeout_q;

   logic             rise;
   logic             fall;
   logic             cnt_at_max;
   logic [WIDTH-1:0] cnt_inc_d;

   sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .d_i    (in_i),
      .rise_o (rise),
      .fall_o (fall)
   );

   assign cnt_at_max = (cnt_q == CNT_MAX);
   // Saturating increment: only a fall landing exactly on CNT_MAX can reach it,
   // and the timeout check fires on the following cycle instead of wrapping.
   assign cnt_inc_d  = cnt_at_max ? CNT_MAX : cnt_q + CNT_ONE;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         high_lat_q <= '0;
         period_q   <= '0;
         high_q     <= '0;
         valid_q    <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (clr_i) begin
            // Clear dominates any edge or timeout in the same cycle.
            state_q    <= IDLE;
            cnt_q      <= '0;
            high_lat_q <= '0;
            period_q   <= '0;
            high_q     <= '0;
            timeout_q  <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  cnt_q <= '0;
                  if (rise) begin
                     state_q <= HIGH;
                     cnt_q   <= CNT_ONE;
                  end
               end
               HIGH: begin
                  if (fall) begin
                     state_q    <= LOW;
                     high_lat_q <= cnt_q;
                     cnt_q      <= cnt_inc_d;
                  end else if (cnt_at_max) begin
                     state_q   <= IDLE;
                     timeout_q <= 1'b1;
                     cnt_q     <= '0;
                  end else begin
                     cnt_q <= cnt_inc_d;
                  end
               end
               LOW: begin
                  if (rise) begin
                     // Closing rise: publish the finished period, start the next one.
                     state_q   <= HIGH;
                     period_q  <= cnt_q;
                     high_q    <= high_lat_q;
                     valid_q   <= 1'b1;
                     timeout_q <= 1'b0;
                     cnt_q     <= CNT_ONE;
                  end else if (cnt_at_max) begin
                     state_q   <= IDLE;
                     timeout_q <= 1'b1;
                     cnt_q     <= '0;
                  end else begin
                     cnt_q <= cnt_inc_d;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end
            endcase
         end
      end
   end

   assign period_o  = period_q;
   assign high_o    = high_q;
   assign valid_o   = valid_q;
   assign timeout_o = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
module tb_pwm_capture;

   localparam int W   = 16;
   localparam int N   = 2;
   localparam int MAX = 65535;

   logic          clk = 1'b0;
   logic          rst;
   logic          din;
   logic          clr;
   logic [W-1:0]  period;
   logic [W-1:0]  high;
   logic          valid;
   logic          timeout;

   logic          in4;
   logic          clr4;
   logic [3:0]    period4;
   logic [3:0]    high4;
   logic          valid4;
   logic          timeout4;

   always #5 clk = ~clk;

   pwm_capture #(.WIDTH(W), .SYNC_STAGES(N)) dut (
      .clk_i(clk), .rst_i(rst), .in_i(din), .clr_i(clr),
      .period_o(period), .high_o(high), .valid_o(valid), .timeout_o(timeout)
   );

   pwm_capture #(.WIDTH(4), .SYNC_STAGES(2)) dut4 (
      .clk_i(clk), .rst_i(rst), .in_i(in4), .clr_i(clr4),
      .period_o(period4), .high_o(high4), .valid_o(valid4), .timeout_o(timeout4)
   );

   int n_vec;
   int n_err;

   // Reference model: time-stamp based. s is the input delayed N cycles;
   // period = time between rises, high = time from rise to fall.
   logic [N:0] hist;
   int         t;
   bit         m_ref;
   int         m_trise;
   int         m_hl;
   int         m_period;
   int         m_high;
   bit         m_valid;
   bit         m_timeout;

   int vcnt, last_p, last_h;
   int v4cnt, last_p4, last_h4;

   typedef struct {
      int hi;
      int lo;
      int exp_p;
      int exp_h;
   } pat_t;

   pat_t tbl[6];

   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      hist      = '0;
      t         = 0;
      m_ref     = 1'b0;
      m_trise   = 0;
      m_hl      = 0;
      m_period  = 0;
      m_high    = 0;
      m_valid   = 1'b0;
      m_timeout = 1'b0;
   endtask

   task automatic model_step(input logic in_v, input logic clr_v);
      logic s, sd;
      bit   rise, fall;
      int   el;
      s    = hist[N-1];
      sd   = hist[N];
      rise = s && !sd;
      fall = !s && sd;
      m_valid = 1'b0;
      if (clr_v) begin
         m_ref     = 1'b0;
         m_period  = 0;
         m_high    = 0;
         m_timeout = 1'b0;
      end else if (!m_ref) begin
         if (rise) begin
            m_ref   = 1'b1;
            m_trise = t;
         end
      end else begin
         el = t - m_trise;
         if (rise) begin
            m_period  = (el > MAX) ? MAX : el;
            m_high    = m_hl;
            m_valid   = 1'b1;
            m_timeout = 1'b0;
            m_trise   = t;
         end else if (fall) begin
            m_hl = el;
         end else if (el >= MAX) begin
            m_ref     = 1'b0;
            m_timeout = 1'b1;
         end
      end
      hist = {hist[N-1:0], in_v};
      t++;
   endtask

   // One clock: sample and compare at the falling edge, then drive the next inputs.
   task automatic step(input logic in_v, input logic clr_v);
      @(negedge clk);
      if (valid) begin
         vcnt++;
         last_p = int'(period);
         last_h = int'(high);
      end
      if (valid4) begin
         v4cnt++;
         last_p4 = int'(period4);
         last_h4 = int'(high4);
      end
      chk($sformatf("period@%0d", t), period, m_period);
      chk($sformatf("high@%0d", t), high, m_high);
      chk($sformatf("valid@%0d", t), valid, m_valid);
      chk($sformatf("timeout@%0d", t), timeout, m_timeout);
      din = in_v;
      clr = clr_v;
      model_step(in_v, clr_v);
   endtask

   task automatic pulse(input int hi, input int lo, input int reps);
      for (int r = 0; r < reps; r++) begin
         for (int i = 0; i < hi; i++) step(1'b1, 1'b0);
         for (int i = 0; i < lo; i++) step(1'b0, 1'b0);
      end
   endtask

   task automatic drive4(input int hi, input int lo);
      for (int i = 0; i < hi; i++) begin step(1'b0, 1'b0); in4 = 1'b1; end
      for (int i = 0; i < lo; i++) begin step(1'b0, 1'b0); in4 = 1'b0; end
   endtask

   initial begin
      int base;
      n_vec = 0; n_err = 0;
      vcnt = 0; last_p = 0; last_h = 0;
      v4cnt = 0; last_p4 = 0; last_h4 = 0;
      tbl[0] = '{3, 7, 10, 3};
      tbl[1] = '{2, 4, 6, 2};
      tbl[2] = '{3, 5, 8, 3};
      tbl[3] = '{5, 1, 6, 5};
      tbl[4] = '{1, 9, 10, 1};
      tbl[5] = '{1, 1, 2, 1};

      rst = 1'b1; din = 1'b0; clr = 1'b0; in4 = 1'b0; clr4 = 1'b0;
      model_reset();
      #22 rst = 1'b0;

      // Reset state
      step(1'b0, 1'b0);
      chk("rst_period4", period4, 0);
      chk("rst_timeout4", timeout4, 0);
      chk("rst_valid4", valid4, 0);

      // Narrow instance: measurement, timeout at cnt=15, recovery.
      repeat (3) drive4(2, 3);
      chk("w4_cnt_a", v4cnt, 2);
      chk("w4_period_a", last_p4, 5);
      chk("w4_high_a", last_h4, 2);
      for (int i = 0; i < 22; i++) begin
         step(1'b0, 1'b0);
         if (i == 17) chk("w4_timeout_before", timeout4, 0);
         if (i == 18) chk("w4_timeout_at", timeout4, 1);
         in4 = 1'b1;
      end
      chk("w4_cnt_b", v4cnt, 3);
      chk("w4_period_kept", period4, 5);
      chk("w4_high_kept", high4, 2);
      chk("w4_timeout_sticky", timeout4, 1);
      drive4(0, 4);
      drive4(3, 4);
      chk("w4_first_rise_cnt", v4cnt, 3);
      chk("w4_first_rise_timeout", timeout4, 1);
      repeat (2) drive4(3, 4);
      chk("w4_cnt_c", v4cnt, 5);
      chk("w4_period_c", last_p4, 7);
      chk("w4_high_c", last_h4, 3);
      chk("w4_timeout_cleared", timeout4, 0);

      // Table of fixed patterns on the wide instance.
      for (int k = 0; k < 6; k++) begin
         pulse(tbl[k].hi, tbl[k].lo, 4);
         chk($sformatf("tbl%0d_period", k), last_p, tbl[k].exp_p);
         chk($sformatf("tbl%0d_high", k), last_h, tbl[k].exp_h);
      end

      // Held low then a single rise: no valid.
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      vcnt = 0;
      repeat (4) step(1'b0, 1'b0);
      repeat (30) step(1'b1, 1'b0);
      chk("single_rise_no_valid", vcnt, 0);

      // Clear coinciding with a completing rise.
      step(1'b0, 1'b1);
      repeat (3) step(1'b0, 1'b0);
      pulse(3, 5, 2);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      step(1'b0, 1'b0);
      chk("clr_period", period, 0);
      chk("clr_high", high, 0);
      chk("clr_valid", valid, 0);
      base = vcnt;
      repeat (4) step(1'b0, 1'b0);
      pulse(3, 5, 1);
      chk("clr_first_rise", vcnt, base);
      pulse(3, 5, 1);
      chk("clr_second_rise", vcnt, base + 1);
      chk("clr_resume_period", last_p, 8);
      chk("clr_resume_high", last_h, 3);

      // Asynchronous reset mid-HIGH.
      pulse(3, 7, 3);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("arst_period", period, 0);
      chk("arst_high", high, 0);
      chk("arst_valid", valid, 0);
      chk("arst_timeout", timeout, 0);
      #5 rst = 1'b0;
      model_reset();
      base = vcnt;
      pulse(3, 7, 3);
      chk("arst_resume_cnt", vcnt, base + 2);
      chk("arst_resume_period", last_p, 10);
      chk("arst_resume_high", last_h, 3);

      // Randomized patterns with occasional clears.
      for (int k = 0; k < 30; k++) begin
         int hi, lo;
         hi = $urandom_range(1, 12);
         lo = $urandom_range(1, 12);
         for (int i = 0; i < hi; i++) step(1'b1, $urandom_range(0, 39) == 0);
         for (int i = 0; i < lo; i++) step(1'b0, $urandom_range(0, 39) == 0);
      end
      for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
